mpr121_i2c_line_conditioner: RTL and testbench

Conditions the MPR121 I2C lines between the bidirectional SCL/SDA pad cells and the I2C master inside khu_sensor_top. Raw pad inputs are synchronized and glitch-filtered, and the block produces clean SCL/SDA levels, edge pulses, START/STOP detection and bus-busy status. Using the master's drive enables, it also flags clock stretching, arbitration loss and a stuck-low SCL.

---
 rtl/mpr121_i2c_pkg.sv | 13 +
 rtl/i2c_glitch_filter.sv | 50 +++++
 rtl/mpr121_i2c_line_conditioner.sv | 111 +++++++++++
 tb/tb_mpr121_i2c_line_conditioner.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpr121_i2c_pkg.sv
// Shared defaults for the MPR121 I2C line conditioner and the release-settle latency helper.
package mpr121_i2c_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_FILTER_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // Cycles from a released drive enable until the pad level it allows is visible after filtering.
  function automatic int calc_lat(input int sync_stages, input int filter_cycles);
    return sync_stages + filter_cycles + 1;
  endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchronizes one raw I2C pad line and filters it; level/rise/fall are registered.
// The level changes SYNC_STAGES + FILTER_CYCLES edges after a stable pad change.
module i2c_glitch_filter
  import mpr121_i2c_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle_nxt
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sample;
  logic                   differ;

  assign sample = sync_q[SYNC_STAGES-1];
  assign differ = (sample != level);
  // Exposed so the parent can register condition pulses coincident with this filter's edge.
  assign toggle_nxt = differ && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      if (!differ || toggle_nxt)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;
      level <= level ^ toggle_nxt;
      rise  <= toggle_nxt && !level;
      fall  <= toggle_nxt && level;
    end
  end

endmodule

// File: rtl/mpr121_i2c_line_conditioner.sv
// Conditions MPR121 SCL/SDA pads: filtered levels, edges, START/STOP, busy, stretch, arbitration, stuck bus.
// All outputs are registered; condition pulses coincide with the filtered edge, BUSY/STRETCH follow one edge later.
module mpr121_i2c_line_conditioner
  import mpr121_i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_SCL_PAD,
  input  logic i_SDA_PAD,
  input  logic i_SCL_OE,
  input  logic i_SDA_OE,
  output logic o_SCL,
  output logic o_SDA,
  output logic o_SCL_RISE,
  output logic o_SCL_FALL,
  output logic o_START,
  output logic o_STOP,
  output logic o_BUSY,
  output logic o_SCL_STRETCH,
  output logic o_ARB_LOST,
  output logic o_BUS_STUCK
);

  localparam int LAT = calc_lat(SYNC_STAGES, FILTER_CYCLES);
  localparam int RW  = $clog2(LAT + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] REL_MAX = RW'(LAT);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  logic scl_tog, sda_tog;
  logic sda_rise, sda_fall;
  logic scl_nxt, sda_nxt;

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk        (i_CLK),
    .rst        (i_RST),
    .pad        (i_SCL_PAD),
    .level      (o_SCL),
    .rise       (o_SCL_RISE),
    .fall       (o_SCL_FALL),
    .toggle_nxt (scl_tog)
  );

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk        (i_CLK),
    .rst        (i_RST),
    .pad        (i_SDA_PAD),
    .level      (o_SDA),
    .rise       (sda_rise),
    .fall       (sda_fall),
    .toggle_nxt (sda_tog)
  );

  assign scl_nxt = o_SCL ^ scl_tog;
  assign sda_nxt = o_SDA ^ sda_tog;

  logic [RW-1:0] scl_rel_q, sda_rel_q, scl_rel_nxt, sda_rel_nxt;
  logic [TW-1:0] low_cnt_q, low_cnt_nxt;

  always_comb begin
    scl_rel_nxt = scl_rel_q;
    sda_rel_nxt = sda_rel_q;
    low_cnt_nxt = low_cnt_q;
    if (i_SCL_OE)
      scl_rel_nxt = '0;
    else if (scl_rel_q != REL_MAX)
      scl_rel_nxt = scl_rel_q + 1'b1;
    if (i_SDA_OE)
      sda_rel_nxt = '0;
    else if (sda_rel_q != REL_MAX)
      sda_rel_nxt = sda_rel_q + 1'b1;
    // SCL coming back high clears the timeout in the same edge it becomes visible.
    if (scl_nxt)
      low_cnt_nxt = '0;
    else if (!o_SCL && (low_cnt_q != TO_MAX))
      low_cnt_nxt = low_cnt_q + 1'b1;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      scl_rel_q     <= '0;
      sda_rel_q     <= '0;
      low_cnt_q     <= '0;
      o_START       <= 1'b0;
      o_STOP        <= 1'b0;
      o_BUSY        <= 1'b0;
      o_SCL_STRETCH <= 1'b0;
      o_ARB_LOST    <= 1'b0;
      o_BUS_STUCK   <= 1'b0;
    end else begin
      scl_rel_q   <= scl_rel_nxt;
      sda_rel_q   <= sda_rel_nxt;
      low_cnt_q   <= low_cnt_nxt;
      // A simultaneous SCL edge makes the SDA edge ambiguous, so no condition is reported.
      o_START     <= sda_tog && o_SDA && o_SCL && !scl_tog;
      o_STOP      <= sda_tog && !o_SDA && o_SCL && !scl_tog;
      if (o_START)
        o_BUSY <= 1'b1;
      else if (o_STOP)
        o_BUSY <= 1'b0;
      o_SCL_STRETCH <= (scl_rel_q == REL_MAX) && !o_SCL;
      o_ARB_LOST    <= scl_tog && !o_SCL && !i_SDA_OE && (sda_rel_nxt == REL_MAX) && !sda_nxt;
      o_BUS_STUCK   <= (low_cnt_nxt == TO_MAX);
    end
  end

endmodule

// File: tb/tb_mpr121_i2c_line_conditioner.sv
// Randomized scenario bench for the I2C line conditioner against a window-based behavioural model.
module tb_mpr121_i2c_line_conditioner;

  localparam int S   = 2;
  localparam int F   = 4;
  localparam int T   = 100;
  localparam int LAT = S + F + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_pad = 1'b1, sda_pad = 1'b1, scl_oe = 1'b0, sda_oe = 1'b0;
  logic o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_stretch, o_arb, o_stuck;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic scl;
    logic sda;
    logic scl_oe;
    logic sda_oe;
    logic rst;
  } stim_t;
  stim_t sq[$];

  always #5 clk = ~clk;

  mpr121_i2c_line_conditioner #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_SCL_PAD     (scl_pad),
    .i_SDA_PAD     (sda_pad),
    .i_SCL_OE      (scl_oe),
    .i_SDA_OE      (sda_oe),
    .o_SCL         (o_scl),
    .o_SDA         (o_sda),
    .o_SCL_RISE    (o_rise),
    .o_SCL_FALL    (o_fall),
    .o_START       (o_start),
    .o_STOP        (o_stop),
    .o_BUSY        (o_busy),
    .o_SCL_STRETCH (o_stretch),
    .o_ARB_LOST    (o_arb),
    .o_BUS_STUCK   (o_stuck)
  );

  // Reference model: a filtered line flips once the delayed pad has disagreed for the last F samples.
  bit m_scl, m_sda, e_rise, e_fall, e_start, e_stop, e_busy, e_stretch, e_arb, e_stuck;
  bit hq_c[$];
  bit hq_d[$];
  int run_c, run_d, low_run;

  always @(posedge clk) begin
    bit tog_c, tog_d, ns, nd;
    if (rst) begin
      hq_c.delete();
      hq_d.delete();
      for (int i = 0; i < S + F; i++) begin
        hq_c.push_back(1'b1);
        hq_d.push_back(1'b1);
      end
      m_scl = 1; m_sda = 1; e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0;
      e_busy = 0; e_stretch = 0; e_arb = 0; e_stuck = 0;
      run_c = 0; run_d = 0; low_run = 0;
    end else begin
      hq_c.push_back(scl_pad);
      hq_d.push_back(sda_pad);
      if (hq_c.size() > 64) begin
        void'(hq_c.pop_front());
        void'(hq_d.pop_front());
      end
      tog_c = 1; tog_d = 1;
      for (int j = 0; j < F; j++) begin
        if (hq_c[hq_c.size() - 1 - S - j] == m_scl) tog_c = 0;
        if (hq_d[hq_d.size() - 1 - S - j] == m_sda) tog_d = 0;
      end
      ns = m_scl ^ tog_c;
      nd = m_sda ^ tog_d;
      if (e_start) e_busy = 1;
      else if (e_stop) e_busy = 0;
      e_stretch = (run_c >= LAT) && !m_scl;
      run_c = scl_oe ? 0 : run_c + 1;
      run_d = sda_oe ? 0 : run_d + 1;
      e_rise  = tog_c && ns;
      e_fall  = tog_c && !ns;
      e_start = tog_d && !nd && m_scl && !tog_c;
      e_stop  = tog_d && nd && m_scl && !tog_c;
      e_arb   = e_rise && (run_d >= LAT) && !nd;
      if (ns) low_run = 0;
      else if (!m_scl) low_run++;
      e_stuck = (low_run >= T);
      m_scl = ns;
      m_sda = nd;
    end
  end

  logic [9:0] obs, expv;
  assign obs  = {o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_stretch, o_arb, o_stuck};
  assign expv = {m_scl, m_sda, e_rise, e_fall, e_start, e_stop, e_busy, e_stretch, e_arb, e_stuck};

  task automatic hold(input logic c, input logic d, input logic co, input logic dx, input int n);
    for (int i = 0; i < n; i++) sq.push_back({c, d, co, dx, 1'b0});
  endtask

  // Master-driven bit: data changes mid-low, SCL high for 10 cycles.
  task automatic push_bit(input logic prev, input logic b);
    hold(1'b0, prev, 1'b1, !prev, 3);
    hold(1'b0, b, 1'b1, !b, 7);
    hold(1'b1, b, 1'b0, !b, 10);
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    sq.delete();
    for (int i = 0; i < 3; i++) sq.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    hold(1'b1, 1'b1, 1'b0, 1'b0, 100);
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL reset_vec i=%0d got=%b exp=%b", i, obs, expv); end
      if (i >= 1 && i <= 3) begin
        total++;
        if (obs !== 10'b1100000000) begin bad++; $display("FAIL reset_values i=%0d got=%b exp=1100000000", i, obs); end
      end
      if (i > 3) pulses += int'(o_rise | o_fall | o_start | o_stop | o_arb | o_busy);
      {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 4; r++) begin
      int lows, starts, len;
      lows = 0; starts = 0;
      len = (r == 0) ? F - 1 : $urandom_range(1, F - 1);
      sq.delete();
      hold(1'b1, 1'b1, 1'b0, 1'b0, 10);
      hold(1'b1, 1'b0, 1'b0, 1'b0, len);
      hold(1'b1, 1'b1, 1'b0, 1'b0, 15);
      for (int i = 0; i < sq.size(); i++) begin
        @(negedge clk);
        total++;
        if (obs !== expv) begin bad++; $display("FAIL spike_vec i=%0d got=%b exp=%b", i, obs, expv); end
        lows += int'(!o_sda);
        starts += int'(o_start);
        {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
      end
      total++;
      if (lows !== 0 || starts !== 0) begin
        bad++; $display("FAIL spike_reject len=%0d sda_low=%0d starts=%0d exp=0/0", len, lows, starts);
      end
    end
    for (int r = 0; r < 4; r++) begin
      int fall_i, start_i, busy_i, len;
      fall_i = -1; start_i = -1; busy_i = -1;
      len = (r == 0) ? F : $urandom_range(F, F + 5);
      sq.delete();
      hold(1'b1, 1'b1, 1'b0, 1'b0, 10);
      hold(1'b1, 1'b0, 1'b0, 1'b0, len);
      hold(1'b1, 1'b1, 1'b0, 1'b0, 20);
      for (int i = 0; i < sq.size(); i++) begin
        @(negedge clk);
        total++;
        if (obs !== expv) begin bad++; $display("FAIL pass_vec i=%0d got=%b exp=%b", i, obs, expv); end
        if (!o_sda && fall_i < 0) fall_i = i;
        if (o_start && start_i < 0) start_i = i;
        if (o_busy && busy_i < 0) busy_i = i;
        {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
      end
      total++;
      if (fall_i !== 10 + S + F || start_i !== 10 + S + F || busy_i !== 11 + S + F) begin
        bad++; $display("FAIL pass_timing len=%0d fall=%0d start=%0d busy=%0d exp=%0d/%0d/%0d",
                        len, fall_i, start_i, busy_i, 10 + S + F, 10 + S + F, 11 + S + F);
      end
    end
  endtask

  task automatic test_transfer();
    int rises, starts, stops, busy_drops, rep_starts, arbs;
    logic prev, b, last_busy;
    rises = 0; starts = 0; stops = 0; busy_drops = 0; rep_starts = 0; arbs = 0; last_busy = 0;
    sq.delete();
    hold(1'b1, 1'b1, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 1'b0, 1'b1, 10);
    prev = 1'b0;
    for (int k = 0; k < 9; k++) begin
      b = (k == 8) ? 1'b0 : 1'($urandom_range(0, 1));
      push_bit(prev, b);
      prev = b;
    end
    hold(1'b1, 1'b1, 1'b0, 1'b0, 20);
    hold(1'b1, 1'b0, 1'b0, 1'b1, 10);
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = 1'($urandom_range(0, 1));
      push_bit(prev, b);
      prev = b;
    end
    push_bit(prev, 1'b1);
    hold(1'b1, 1'b0, 1'b0, 1'b1, 10);
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = (k == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      push_bit(prev, b);
      prev = b;
    end
    hold(1'b1, 1'b1, 1'b0, 1'b0, 20);
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL xfer_vec i=%0d got=%b exp=%b", i, obs, expv); end
      rises += int'(o_rise);
      starts += int'(o_start);
      stops += int'(o_stop);
      arbs += int'(o_arb);
      rep_starts += int'(o_start && o_busy);
      busy_drops += int'(last_busy && !o_busy);
      last_busy = o_busy;
      {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
    end
    total++;
    if (rises !== 18 || starts !== 3 || stops !== 2 || rep_starts !== 1 || busy_drops !== 2 || arbs !== 0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL xfer_counts rise=%0d start=%0d stop=%0d rep=%0d drop=%0d arb=%0d busy=%b exp=18/3/2/1/2/0/0",
                      rises, starts, stops, rep_starts, busy_drops, arbs, o_busy);
    end
  endtask

  task automatic test_stretch();
    for (int r = 0; r < 3; r++) begin
      int h, first_s, end_s;
      h = (r == 0) ? 50 : $urandom_range(20, 70);
      first_s = -1; end_s = -1;
      sq.delete();
      hold(1'b0, 1'b1, 1'b1, 1'b0, 20);
      hold(1'b0, 1'b1, 1'b0, 1'b0, h);
      hold(1'b1, 1'b1, 1'b0, 1'b0, 20);
      for (int i = 0; i < sq.size(); i++) begin
        @(negedge clk);
        total++;
        if (obs !== expv) begin bad++; $display("FAIL stretch_vec i=%0d got=%b exp=%b", i, obs, expv); end
        if (o_stretch && first_s < 0) first_s = i;
        if (!o_stretch && first_s >= 0 && end_s < 0) end_s = i;
        {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
      end
      total++;
      if (first_s !== 20 + 8 || end_s !== 20 + h + S + F + 1) begin
        bad++; $display("FAIL stretch_window h=%0d start=%0d end=%0d exp=%0d/%0d", h, first_s, end_s, 28, 20 + h + S + F + 1);
      end
    end
  endtask

  task automatic test_arbitration();
    for (int r = 0; r < 2; r++) begin
      int arbs;
      logic dx;
      dx = 1'(r);
      arbs = 0;
      sq.delete();
      hold(1'b0, 1'b1, 1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 1'b1, dx, 10);
      hold(1'b1, 1'b0, 1'b0, dx, 15);
      hold(1'b0, 1'b0, 1'b1, dx, 10);
      hold(1'b0, 1'b1, 1'b1, 1'b0, 10);
      hold(1'b1, 1'b1, 1'b0, 1'b0, 10);
      for (int i = 0; i < sq.size(); i++) begin
        @(negedge clk);
        total++;
        if (obs !== expv) begin bad++; $display("FAIL arb_vec i=%0d got=%b exp=%b", i, obs, expv); end
        arbs += int'(o_arb);
        {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
      end
      total++;
      if (arbs !== (r == 0 ? 1 : 0)) begin
        bad++; $display("FAIL arb_count sda_oe=%0d got=%0d exp=%0d", r, arbs, (r == 0 ? 1 : 0));
      end
    end
  endtask

  task automatic test_stuck();
    int fall_i, stuck_i, stuck_at_rise, fall2, stuck2;
    fall_i = -1; stuck_i = -1; stuck_at_rise = -1;
    sq.delete();
    hold(1'b0, 1'b1, 1'b0, 1'b0, 130);
    hold(1'b1, 1'b1, 1'b0, 1'b0, 20);
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL stuck_vec i=%0d got=%b exp=%b", i, obs, expv); end
      if (!o_scl && fall_i < 0) fall_i = i;
      if (o_stuck && stuck_i < 0) stuck_i = i;
      if (o_rise) stuck_at_rise = int'(o_stuck);
      {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
    end
    total++;
    if (fall_i < 0 || stuck_i - fall_i !== T || stuck_at_rise !== 0) begin
      bad++; $display("FAIL stuck_timing fall=%0d stuck=%0d at_rise=%0d exp_delta=%0d exp_rise=0", fall_i, stuck_i, stuck_at_rise, T);
    end
    fall2 = -1; stuck2 = -1;
    sq.delete();
    hold(1'b0, 1'b1, 1'b0, 1'b0, 60);
    sq.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    sq.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    hold(1'b0, 1'b1, 1'b0, 1'b0, 120);
    hold(1'b1, 1'b1, 1'b0, 1'b0, 20);
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL rst_mid_vec i=%0d got=%b exp=%b", i, obs, expv); end
      if (i == 61 || i == 62) begin
        total++;
        if (obs !== 10'b1100000000) begin bad++; $display("FAIL rst_mid_values i=%0d got=%b exp=1100000000", i, obs); end
      end
      if (i > 62 && !o_scl && fall2 < 0) fall2 = i;
      if (i > 62 && o_stuck && stuck2 < 0) stuck2 = i;
      {scl_pad, sda_pad, scl_oe, sda_oe, rst} = sq[i];
    end
    total++;
    if (fall2 !== 62 + S + F || stuck2 !== 62 + S + F + T) begin
      bad++; $display("FAIL rst_mid_timeout fall=%0d stuck=%0d exp=%0d/%0d", fall2, stuck2, 62 + S + F, 62 + S + F + T);
    end
  endtask

  task automatic test_random();
    stim_t cur;
    int run;
    run = 0;
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random_vec i=%0d got=%b exp=%b", i, obs, expv); end
      if (run == 0) begin
        cur.scl    = 1'($urandom_range(0, 1));
        cur.sda    = 1'($urandom_range(0, 1));
        cur.scl_oe = 1'($urandom_range(0, 1));
        cur.sda_oe = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 12);
      end
      run--;
      cur.rst = ($urandom_range(0, 299) == 0);
      {scl_pad, sda_pad, scl_oe, sda_oe, rst} = cur;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_transfer();
    test_stretch();
    test_arbitration();
    test_stuck();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
